// File: rtl/reg_file_pkg.sv
// Shared register-file types for decode and writeback.
// Pure declarations; no timing or flow control.
package reg_file_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [XLEN_DEFAULT-1:0]          xlen_t;
  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bundle for the multi-port register file.
// Reads are combinational, dbg_data lags dbg_addr by one cycle; no handshake.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr,
    input  rd_data, rd_busy, dbg_data
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr,
    output rd_data, rd_busy, dbg_data
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Busy-bit scoreboard: issue sets, any write clears, issue beats clear; r0 never busy.
// State updates at posedge; never stalls.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    end
    // A new producer supersedes the one writing back this cycle.
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and debug port.
// Reads 0 cycles (bypassed), dbg_data 1 cycle; no backpressure, never stalls.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0]    lk_addr [NRD+1];
  logic [XLEN-1:0]  lk_data [NRD+1];
  logic [XLEN-1:0]  dbg_q;

  rf_scoreboard #(.NREGS(NREGS), .NWR(NWR), .AW(AW)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .busy     (busy)
  );

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != '0)
          regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Lookup NRD is the debug port; it shares the read-port priority rules.
  for (genvar p = 0; p <= NRD; p++) begin : g_lookup
    logic            hit;
    logic [XLEN-1:0] byp;

    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == lk_addr[p]) begin
          hit = 1'b1;
          byp = bus.wr_data[w*XLEN +: XLEN];
        end
      end
    end

    assign lk_data[p] = (lk_addr[p] == '0) ? '0 : (hit ? byp : regs[lk_addr[p]]);

    if (p < NRD) begin : g_rd
      assign lk_addr[p]                    = bus.rd_addr[p*AW +: AW];
      assign bus.rd_data[p*XLEN +: XLEN]   = lk_data[p];
      assign bus.rd_busy[p]                = busy[lk_addr[p]] & ~hit;
    end else begin : g_dbg
      assign lk_addr[p] = bus.dbg_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dbg_q <= '0;
    else     dbg_q <= lk_data[NRD];
  end

  assign bus.dbg_data = dbg_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed literal checks plus randomized traffic against an array model.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  logic [XLEN-1:0] m_dbg;
  bit              model_valid = 1'b0;

  // What a reader of address a must see right now.
  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    for (int w = 0; w < NWR; w++)
      if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) v = bus.wr_data[w*XLEN +: XLEN];
    return v;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    for (int w = 0; w < NWR; w++)
      if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Model state advance at each posedge.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] <= '0;
        m_busy[r] <= 1'b0;
      end
      m_dbg       <= '0;
      model_valid <= 1'b1;
    end else if (model_valid) begin
      m_dbg <= exp_read(bus.dbg_addr);
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != 0)
          m_regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != 0)
          m_busy[bus.wr_addr[w*AW +: AW]] <= 1'b0;
      end
      if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] <= 1'b1;
    end
  end

  // Compare process: every cycle once the model is anchored by a reset.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    if (model_valid) begin
      for (int p = 0; p < NRD; p++) begin
        a = bus.rd_addr[p*AW +: AW];
        checks++;
        if (bus.rd_data[p*XLEN +: XLEN] !== exp_read(a)) begin
          errors++;
          $display("FAIL rd_data[%0d] addr %0d: got %h expected %h", p, a,
                   bus.rd_data[p*XLEN +: XLEN], exp_read(a));
        end
        checks++;
        if (bus.rd_busy[p] !== exp_busy(a)) begin
          errors++;
          $display("FAIL rd_busy[%0d] addr %0d: got %b expected %b", p, a,
                   bus.rd_busy[p], exp_busy(a));
        end
      end
      checks++;
      if (bus.dbg_data !== m_dbg) begin
        errors++;
        $display("FAIL dbg_data: got %h expected %h", bus.dbg_data, m_dbg);
      end
    end
  end

  task automatic lit(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.wr_en[port]               = 1'b1;
    bus.wr_addr[port*AW +: AW]    = a;
    bus.wr_data[port*XLEN +: XLEN] = d;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    bus.iss_en   = 1'b1;
    bus.iss_addr = a;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS-1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    bus.rd_addr  = '0;
    bus.dbg_addr = '0;
    cyc();
    cyc();

    // Reset state
    rst = 1'b0;
    bus.rd_addr = {AW'(6), AW'(5)};
    @(negedge clk);
    lit("reset_busy", XLEN'(bus.rd_busy), '0);
    lit("reset_dbg", bus.dbg_data, '0);
    lit("reset_rd0", bus.rd_data[0 +: XLEN], '0);
    cyc();

    // Reset discards state and same-cycle write
    wr(0, 5, 64'hDEAD);
    iss(6);
    cyc();
    rst = 1'b1;
    idle();
    wr(0, 6, 64'h1);
    cyc();
    rst = 1'b0;
    idle();
    @(negedge clk);
    lit("rst_r5", bus.rd_data[0 +: XLEN], '0);
    lit("rst_r6", bus.rd_data[XLEN +: XLEN], '0);
    lit("rst_busy", XLEN'(bus.rd_busy), '0);
    lit("rst_dbg", bus.dbg_data, '0);
    cyc();

    // Register 0 is inert
    wr(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    iss(0);
    bus.rd_addr = '0;
    @(negedge clk);
    lit("r0_bypass", bus.rd_data[0 +: XLEN], '0);
    cyc();
    idle();
    @(negedge clk);
    lit("r0_read", bus.rd_data[XLEN +: XLEN], '0);
    lit("r0_busy", XLEN'(bus.rd_busy), '0);
    cyc();

    // Bypass then stored value
    wr(0, 7, 64'h1234);
    bus.rd_addr = {AW'(7), AW'(7)};
    @(negedge clk);
    lit("bypass_p0", bus.rd_data[0 +: XLEN], 64'h1234);
    lit("bypass_p1", bus.rd_data[XLEN +: XLEN], 64'h1234);
    cyc();
    idle();
    @(negedge clk);
    lit("stored_p0", bus.rd_data[0 +: XLEN], 64'h1234);
    lit("stored_p1", bus.rd_data[XLEN +: XLEN], 64'h1234);
    cyc();

    // Multi-write priority
    wr(0, 3, 64'hAA);
    wr(1, 3, 64'hBB);
    bus.rd_addr = {AW'(0), AW'(3)};
    @(negedge clk);
    lit("prio_bypass", bus.rd_data[0 +: XLEN], 64'hBB);
    cyc();
    idle();
    @(negedge clk);
    lit("prio_stored", bus.rd_data[0 +: XLEN], 64'hBB);
    cyc();

    // Scoreboard
    iss(9);
    bus.rd_addr = {AW'(9), AW'(9)};
    cyc();
    idle();
    @(negedge clk);
    lit("sb_issue", XLEN'(bus.rd_busy), 64'h3);
    cyc();
    @(negedge clk);
    lit("sb_hold", XLEN'(bus.rd_busy), 64'h3);
    cyc();
    wr(0, 9, 64'h99);
    @(negedge clk);
    lit("sb_wb_mask", XLEN'(bus.rd_busy), '0);
    cyc();
    idle();
    wr(1, 9, 64'h9A);
    iss(9);
    cyc();
    idle();
    @(negedge clk);
    lit("sb_issue_wins", XLEN'(bus.rd_busy), 64'h3);
    cyc();

    // Debug latency
    wr(0, 2, 64'h77);
    cyc();
    idle();
    wr(0, 31, 64'h55);
    bus.dbg_addr = 31;
    cyc();
    idle();
    bus.dbg_addr = 2;
    @(negedge clk);
    lit("dbg_lat1", bus.dbg_data, 64'h55);
    cyc();
    @(negedge clk);
    lit("dbg_r2", bus.dbg_data, 64'h77);
    cyc();

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      idle();
      for (int w = 0; w < NWR; w++)
        if ($urandom_range(0, 1) == 1) wr(w, rand_addr(), {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) iss(rand_addr());
      for (int p = 0; p < NRD; p++) bus.rd_addr[p*AW +: AW] = rand_addr();
      bus.dbg_addr = rand_addr();
      cyc();
    end

    rst = 1'b0;
    idle();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
